// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: operation encodings shared by the logic unit pipeline
package logic_unit_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
    localparam logic [OP_W-1:0] OP_AND  = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;
endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: combinational bitwise operation select, (op, a, b) -> s
module logic_op_core import logic_unit_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s
);
    always_comb
        s = op == OP_NOT  ? ~a :
            op == OP_AND  ? a & b :
            op == OP_OR   ? a | b :
            op == OP_XOR  ? a ^ b :
            op == OP_NAND ? ~(a & b) :
            op == OP_NOR  ? ~(a | b) :
            op == OP_XNOR ? ~(a ^ b) : a;
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage valid/ready bitwise logic unit with result flags; LOGIC_UNIT_POPCNT_EN adds out_popcnt
module logic_unit_pipe import logic_unit_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
`ifdef LOGIC_UNIT_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);
    logic             s1_v, s2_v, s1_adv, s2_adv;
    logic [OP_W-1:0]  s1_op;
    logic [WIDTH-1:0] s1_a, s1_b, s1_s;
    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;
    logic_op_core #(.WIDTH(WIDTH)) u_core (.op(s1_op), .a(s1_a), .b(s1_b), .s(s1_s));
`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int PC_W = $clog2(WIDTH+1);
    logic [PC_W-1:0] s1_pc;
    always_comb begin
        s1_pc = '0;
        for (int i = 0; i < WIDTH; i++) s1_pc = s1_pc + PC_W'(s1_s[i]);
    end
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_op <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_op <= in_op;
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    // S2 only captures real beats so outputs hold across bubbles and stalls
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s2_v       <= 1'b0;
            out_s      <= '0;
            out_zero   <= 1'b0;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
`ifdef LOGIC_UNIT_POPCNT_EN
            out_popcnt <= '0;
`endif
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_s      <= s1_s;
                out_zero   <= s1_s == '0;
                out_ones   <= &s1_s;
                out_parity <= ^s1_s;
`ifdef LOGIC_UNIT_POPCNT_EN
                out_popcnt <= s1_pc;
`endif
            end
        end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized and directed checks of logic_unit_pipe against a truth-table model
module tb_logic_unit_pipe;
    localparam int W  = 16;
    localparam int W8 = 8;
    localparam int N_RAND = 10000;
    // per-op truth tables, nibble per op, bit index {a,b}
    localparam logic [31:0] TT = 32'hC9176E83;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [2:0]    in_op = '0;
    logic [W-1:0]  in_a = '0, in_b = '0, out_s;
    logic          out_zero, out_ones, out_parity;
    logic          e_in_valid = 1'b0, e_in_ready, e_out_valid, e_out_ready = 1'b1;
    logic [2:0]    e_in_op = '0;
    logic [W8-1:0] e_in_a = '0, e_in_b = '0, e_out_s;
    logic          e_out_zero, e_out_ones, e_out_parity;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [$clog2(W+1)-1:0]  out_popcnt;
    logic [$clog2(W8+1)-1:0] e_out_popcnt;
`endif

    int errors = 0;
    int checks = 0;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity)
`ifdef LOGIC_UNIT_POPCNT_EN
        , .out_popcnt(out_popcnt)
`endif
    );

    logic_unit_pipe #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_op(e_in_op),
        .in_a(e_in_a), .in_b(e_in_b), .out_valid(e_out_valid), .out_ready(e_out_ready), .out_s(e_out_s),
        .out_zero(e_out_zero), .out_ones(e_out_ones), .out_parity(e_out_parity)
`ifdef LOGIC_UNIT_POPCNT_EN
        , .out_popcnt(e_out_popcnt)
`endif
    );

    function automatic logic [63:0] ref_s(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int w);
        logic [31:0] tt_all;
        logic [3:0]  tt;
        logic [63:0] r;
        tt_all = TT;
        tt = tt_all[op*4 +: 4];
        r = '0;
        for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic int ones_cnt(input logic [63:0] s, input int w);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) n += int'(s[i]);
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        e_in_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_op = 3'($urandom);
            in_a = 16'($urandom | 1);
            in_b = 16'($urandom);
            e_in_op = 3'd7;
            e_in_a = 8'hA5;
            step();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_s, out_zero, out_ones, out_parity, in_ready} !== {1'b0, 16'h0, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset16: got valid=%b s=%h z=%b o=%b p=%b rdy=%b, want 0 0000 0 0 0 1",
                     out_valid, out_s, out_zero, out_ones, out_parity, in_ready);
        end
        checks++;
        if ({e_out_valid, e_out_s, e_out_zero, e_out_ones, e_out_parity, e_in_ready} !== {1'b0, 8'h0, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset8: got valid=%b s=%h rdy=%b, want 0 00 1", e_out_valid, e_out_s, e_in_ready);
        end
`ifdef LOGIC_UNIT_POPCNT_EN
        checks++;
        if (out_popcnt !== '0) begin
            errors++;
            $display("FAIL reset_popcnt: got %0d want 0", out_popcnt);
        end
`endif
        in_valid = 1'b0;
        e_in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || e_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard: got valid=%b/%b want 0/0", out_valid, e_out_valid);
            end
            step();
        end
    endtask

    task automatic test_not();
        in_op = 3'b000;
        in_a = 16'h00FF;
        in_b = 16'h1234;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL not_latency1: got out_valid=%b want 0", out_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, out_s, out_zero, out_ones, out_parity} !== {1'b1, 16'hFF00, 3'b000}) begin
            errors++;
            $display("FAIL not_result: got valid=%b s=%h z=%b o=%b p=%b want 1 ff00 0 0 0",
                     out_valid, out_s, out_zero, out_ones, out_parity);
        end
        step();
    endtask

    task automatic test_all_ops();
        logic [15:0] exp_ops [7];
        exp_ops = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
        in_a = 16'hF0F0;
        in_b = 16'hFF00;
        for (int c = 0; c < 9; c++) begin
            in_valid = c < 7;
            in_op = 3'(c + 1);
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_s !== exp_ops[c-2]) begin
                    errors++;
                    $display("FAIL all_ops[%0d]: got valid=%b s=%h want 1 %h", c - 1, out_valid, out_s, exp_ops[c-2]);
                end
            end
            step();
        end
    endtask

    task automatic test_flags();
        in_op = 3'b011;
        in_a = 16'h1234;
        in_b = 16'h1234;
        in_valid = 1'b1;
        step();
        in_op = 3'b101;
        in_a = 16'h0000;
        in_b = 16'h0000;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_s, out_zero, out_ones, out_parity} !== {1'b1, 16'h0000, 3'b100}) begin
            errors++;
            $display("FAIL flags_xor: got valid=%b s=%h z=%b o=%b p=%b want 1 0000 1 0 0",
                     out_valid, out_s, out_zero, out_ones, out_parity);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, out_s, out_zero, out_ones, out_parity} !== {1'b1, 16'hFFFF, 3'b010}) begin
            errors++;
            $display("FAIL flags_nor: got valid=%b s=%h z=%b o=%b p=%b want 1 ffff 0 1 0",
                     out_valid, out_s, out_zero, out_ones, out_parity);
        end
`ifdef LOGIC_UNIT_POPCNT_EN
        checks++;
        if (out_popcnt !== 5'd16) begin
            errors++;
            $display("FAIL flags_popcnt: got %0d want 16", out_popcnt);
        end
`endif
        step();
    endtask

    task automatic test_backpressure();
        logic [2:0]  b_op [5];
        logic [15:0] b_a [5], b_b [5], want;
        int sent, got;
        sent = 0;
        got = 0;
        for (int i = 0; i < 5; i++) begin
            b_op[i] = 3'($urandom);
            b_a[i] = 16'($urandom);
            b_b[i] = 16'($urandom);
        end
        for (int c = 0; c < 40 && got < 5; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid = sent < 5;
            if (sent < 5) begin
                in_op = b_op[sent];
                in_a = b_a[sent];
                in_b = b_b[sent];
            end
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (in_ready !== 1'b0 || sent != 3) begin
                    errors++;
                    $display("FAIL bp_ready_drop: got in_ready=%b sent=%0d want 0 3", in_ready, sent);
                end
            end
            if (c >= 3 && c <= 6) begin
                want = 16'(ref_s(b_op[1], 64'(b_a[1]), 64'(b_b[1]), W));
                checks++;
                if (out_valid !== 1'b1 || out_s !== want) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got valid=%b s=%h want 1 %h", c, out_valid, out_s, want);
                end
            end
            if (out_valid && out_ready) begin
                want = 16'(ref_s(b_op[got], 64'(b_a[got]), 64'(b_b[got]), W));
                checks++;
                if (out_s !== want) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got s=%h want %h", got, out_s, want);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL bp_count: got %0d results want 5", got);
        end
    endtask

    task automatic test_width8();
        e_in_op = 3'b000;
        e_in_a = 8'h0F;
        e_in_valid = 1'b1;
        step();
        e_in_op = 3'b111;
        e_in_a = 8'hFF;
        e_in_b = 8'h00;
        step();
        e_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({e_out_valid, e_out_s, e_out_zero, e_out_ones, e_out_parity} !== {1'b1, 8'hF0, 3'b000}) begin
            errors++;
            $display("FAIL w8_not: got valid=%b s=%h z=%b o=%b p=%b want 1 f0 0 0 0",
                     e_out_valid, e_out_s, e_out_zero, e_out_ones, e_out_parity);
        end
`ifdef LOGIC_UNIT_POPCNT_EN
        checks++;
        if (e_out_popcnt !== 4'd4) begin
            errors++;
            $display("FAIL w8_not_popcnt: got %0d want 4", e_out_popcnt);
        end
`endif
        step();
        @(negedge clk);
        checks++;
        if ({e_out_valid, e_out_s, e_out_zero, e_out_ones, e_out_parity} !== {1'b1, 8'hFF, 3'b010}) begin
            errors++;
            $display("FAIL w8_pass: got valid=%b s=%h z=%b o=%b p=%b want 1 ff 0 1 0",
                     e_out_valid, e_out_s, e_out_zero, e_out_ones, e_out_parity);
        end
`ifdef LOGIC_UNIT_POPCNT_EN
        checks++;
        if (e_out_popcnt !== 4'd8) begin
            errors++;
            $display("FAIL w8_pass_popcnt: got %0d want 8", e_out_popcnt);
        end
`endif
        step();
    endtask

    task automatic test_random();
        logic [15:0] q [$];
        logic [15:0] want;
        int n, sent, got, cyc;
        sent = 0;
        got = 0;
        for (cyc = 0; cyc < 60000 && got < N_RAND; cyc++) begin
            in_valid = sent < N_RAND && $urandom_range(0, 3) != 0;
            in_op = 3'($urandom);
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            checks++;
            if (in_ready !== (out_ready || q.size() < 2)) begin
                errors++;
                $display("FAIL rand_in_ready: got %b want %b (in flight %0d)", in_ready, out_ready || q.size() < 2, q.size());
            end
            if (out_valid === 1'b1) begin
                want = q.size() > 0 ? q[0] : 16'hx;
                n = ones_cnt(64'(want), W);
                checks++;
                if (q.size() == 0 || {out_s, out_zero, out_ones, out_parity} !== {want, n == 0, n == W, n[0]}) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: got s=%h z=%b o=%b p=%b want %h %b %b %b",
                             got, out_s, out_zero, out_ones, out_parity, want, n == 0, n == W, n[0]);
                end
`ifdef LOGIC_UNIT_POPCNT_EN
                checks++;
                if (int'(out_popcnt) != n) begin
                    errors++;
                    $display("FAIL rand_popcnt[%0d]: got %0d want %0d", got, out_popcnt, n);
                end
`endif
                if (out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(16'(ref_s(in_op, 64'(in_a), 64'(in_b), W)));
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != N_RAND || sent != N_RAND) begin
            errors++;
            $display("FAIL rand_count: got %0d of %0d sent, want %0d", got, sent, N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_not();
        test_all_ops();
        test_flags();
        test_backpressure();
        test_width8();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
